// File: rtl/serial_frame_rx.sv
// serial_frame_rx: strobe-sampled serial frame receiver (start, DATA_W data bits LSB first, optional even parity, stop).
// Revision 1.0
`default_nettype none

module serial_frame_rx #(
   parameter int DATA_W    = 8,
   parameter int PARITY_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   input  logic              sin_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_bit;
   logic              par_calc;

   // Even parity holds when data bits and parity bit XOR to zero.
   assign par_calc = (PARITY_EN != 0) ? ((^shreg) ^ par_bit) : 1'b0;

   always_ff @(posedge clk) begin
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         dout    <= '0;
         busy    <= 1'b0;
      end else if (sin_en) begin
         case (state)
            IDLE: begin
               if (!sin) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            DATA: begin
               shreg[bit_cnt] <= sin;
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  state   <= (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            PARITY: begin
               par_bit <= sin;
               state   <= STOP;
            end
            STOP: begin
               if (sin) begin
                  dout       <= shreg;
                  dout_valid <= 1'b1;
                  parity_err <= par_calc;
               end else begin
                  frame_err <= 1'b1;
               end
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frames with a scoreboard queue checked by an output monitor.
`default_nettype none

module tb_serial_frame_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       sin;
   logic       sin_en;
   logic [7:0] dout;
   logic       dout_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         ferr;
      logic [7:0] data;
      bit         perr;
   } exp_t;

   exp_t       q[$];
   logic [7:0] exp_dout = 8'h00;

   serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .sin_en     (sin_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: pops one expected event per output pulse.
   always @(negedge clk) begin
      if (dout_valid || frame_err) begin
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: dout_valid=%0b frame_err=%0b dout=%0h, none expected",
                     dout_valid, frame_err, dout);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("event_kind_frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
            check("event_kind_dout_valid", {31'd0, dout_valid}, {31'd0, ~e.ferr});
            check("event_dout", {24'd0, dout}, {24'd0, e.data});
            check("event_parity_err", {31'd0, parity_err}, {31'd0, e.perr});
         end
      end else if (parity_err) begin
         errors++;
         $display("FAIL parity_err_unqualified: got 1 expected 0 while dout_valid=0");
      end
   end

   task automatic send_bit(input logic b, input int gap);
      sin_en = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      sin    = b;
      sin_en = 1'b1;
      @(posedge clk);
      #1;
      sin_en = 1'b0;
      sin    = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] data, input bit flip_par, input logic stop, input int gap);
      exp_t e;
      if (stop) begin
         e.ferr   = 1'b0;
         e.data   = data;
         e.perr   = flip_par;
         exp_dout = data;
      end else begin
         e.ferr = 1'b1;
         e.data = exp_dout;
         e.perr = 1'b0;
      end
      q.push_back(e);
      send_bit(1'b0, gap);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 8; i++) send_bit(data[i], gap);
      send_bit((^data) ^ flip_par, gap);
      send_bit(stop, gap);
      check("latency_pulse", {31'd0, (dout_valid | frame_err)}, 32'd1);
      check("busy_after_stop", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst    = 1'b1;
      sin    = 1'b0;
      sin_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_dout", {24'd0, dout}, 32'd0);
      check("reset_dout_valid", {31'd0, dout_valid}, 32'd0);
      check("reset_parity_err", {31'd0, parity_err}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst    = 1'b0;
      sin    = 1'b1;
      sin_en = 1'b0;

      send_bit(1'b1, 0);
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      send_bit(1'b1, 0);
      send_frame(8'hA5, 1'b1, 1'b1, 0);
      send_bit(1'b1, 0);
      send_frame(8'h3C, 1'b0, 1'b0, 0);
      check("dout_hold_after_frame_err", {24'd0, dout}, 32'h000000A5);

      // Sparse strobe, back-to-back frames
      send_bit(1'b1, 2);
      send_frame(8'h01, 1'b0, 1'b1, 2);
      send_frame(8'hFF, 1'b0, 1'b1, 2);

      // Reset mid-frame, with strobe asserted to exercise reset priority
      send_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
      rst    = 1'b1;
      sin    = 1'b0;
      sin_en = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      sin    = 1'b1;
      sin_en = 1'b0;
      exp_dout = 8'h00;
      check("midframe_reset_busy", {31'd0, busy}, 32'd0);
      check("midframe_reset_dout", {24'd0, dout}, 32'd0);
      send_bit(1'b1, 0);
      send_frame(8'h5A, 1'b0, 1'b1, 0);

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end

endmodule

`default_nettype wire
